// File: rtl/cic_tx_feeder.sv
// ---------------------------------------------------------------------------
// cic_tx_feeder
//
// Transmit-side sample source for the CIC interpolator. The modulator/host
// writes X/Y sample pairs into a small FIFO. Each time the interpolator
// raises its tie request, the next pair is presented on tdix/tdiy.
// Underrun and overrun are reported as sticky flags.
//
// Ports
//   dclk     data clock, shared with the interpolator
//   rst_n    asynchronous active-low reset
//   xmt      transmit enable; when low, tie is ignored and outputs are zero
//   tie      interpolator request, high for two dclk cycles per sample
//   wr       write strobe for one pair on wdata = {X, Y}
//   wdata    packed sample pair, two's complement
//   flush    synchronous FIFO clear
//   err_clr  clears the udf/ovf sticky flags
//   full     FIFO holds 2^AW pairs
//   level    FIFO occupancy, 0..2^AW
//   tdix     X sample to the interpolator (registered)
//   tdiy     Y sample to the interpolator (registered)
//   tdv      one-cycle pulse when tdix/tdiy are updated
//   udf      sticky underrun flag
//   ovf      sticky overrun flag
//
// Optional feature (macro CIC_TX_FEEDER_HOLD_EN):
//   When defined, an underrun keeps the last valid sample on tdix/tdiy
//   instead of zeroing them, which avoids a step transient in the
//   interpolator. Flush-cycle requests and xmt=0 still zero the outputs.
// ---------------------------------------------------------------------------
module cic_tx_feeder #(
   parameter int DW = 18,
   parameter int AW = 4
) (
   input  logic            dclk,
   input  logic            rst_n,
   input  logic            xmt,
   input  logic            tie,
   input  logic            wr,
   input  logic [2*DW-1:0] wdata,
   input  logic            flush,
   input  logic            err_clr,
   output logic            full,
   output logic [AW:0]     level,
   output logic [DW-1:0]   tdix,
   output logic [DW-1:0]   tdiy,
   output logic            tdv,
   output logic            udf,
   output logic            ovf
);

   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] LEVEL_FULL = {1'b1, {AW{1'b0}}};

   logic [2*DW-1:0] mem [DEPTH];

   logic            tie_q;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     level_q,  level_d;
   logic [DW-1:0]   tdix_q,   tdix_d;
   logic [DW-1:0]   tdiy_q,   tdiy_d;
   logic            tdv_q,    tdv_d;
   logic            udf_q,    udf_d;
   logic            ovf_q,    ovf_d;

   logic            req;
   logic            empty;
   logic            is_full;
   logic            pop;
   logic            push;
   logic            underrun;
   logic            overrun;
   logic [2*DW-1:0] head;

   // One request per tie pulse: only the first cycle tie is seen high.
   assign req     = tie & ~tie_q & xmt;
   assign empty   = (level_q == '0);
   assign is_full = (level_q == LEVEL_FULL);
   assign head    = mem[rd_ptr_q];

   // Flush wins over both pop and push. A request that cannot be served
   // (flush or empty) is an underrun. A write into a full FIFO is only
   // accepted if a pop frees the head slot in the same cycle; the RAM
   // read of the head happens before the write lands, so the two never
   // collide even when both pointers are equal.
   assign pop      = req & ~flush & ~empty;
   assign underrun = req & (flush | empty);
   assign push     = wr & ~flush & (~is_full | pop);
   assign overrun  = wr & ~flush & is_full & ~pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      tdix_d   = tdix_q;
      tdiy_d   = tdiy_q;
      tdv_d    = 1'b0;
      udf_d    = (udf_q & ~err_clr) | underrun;
      ovf_d    = (ovf_q & ~err_clr) | overrun;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         if (push && !pop) begin
            level_d = level_q + (AW+1)'(1);
         end else if (pop && !push) begin
            level_d = level_q - (AW+1)'(1);
         end
      end

      // Output sample register: zero while not transmitting, head on a
      // served request, zero (or held) on underrun.
      if (!xmt) begin
         tdix_d = '0;
         tdiy_d = '0;
      end else if (pop) begin
         tdix_d = head[2*DW-1:DW];
         tdiy_d = head[DW-1:0];
         tdv_d  = 1'b1;
      end else if (underrun) begin
         tdv_d = 1'b1;
`ifdef CIC_TX_FEEDER_HOLD_EN
         if (flush) begin
            tdix_d = '0;
            tdiy_d = '0;
         end
`else
         tdix_d = '0;
         tdiy_d = '0;
`endif
      end
   end

   // Sample storage: no reset so it can map onto a dual-port RAM.
   always_ff @(posedge dclk) begin
      if (push) begin
         mem[wr_ptr_q] <= wdata;
      end
   end

   // Control and output state registers.
   always_ff @(posedge dclk or negedge rst_n) begin
      if (!rst_n) begin
         tie_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         tdix_q   <= '0;
         tdiy_q   <= '0;
         tdv_q    <= 1'b0;
         udf_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         tie_q    <= tie;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         tdix_q   <= tdix_d;
         tdiy_q   <= tdiy_d;
         tdv_q    <= tdv_d;
         udf_q    <= udf_d;
         ovf_q    <= ovf_d;
      end
   end

   assign full  = is_full;
   assign level = level_q;
   assign tdix  = tdix_q;
   assign tdiy  = tdiy_q;
   assign tdv   = tdv_q;
   assign udf   = udf_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_cic_tx_feeder.sv
// ---------------------------------------------------------------------------
// tb_cic_tx_feeder
//
// Directed self-checking bench for cic_tx_feeder (DW=18, AW=4). Inputs are
// driven 1 ns after each rising dclk edge and outputs are sampled at the
// same point, so every check sees the result of the preceding edge.
// Expected underrun outputs follow CIC_TX_FEEDER_HOLD_EN if defined.
// ---------------------------------------------------------------------------
module tb_cic_tx_feeder;

   localparam int DW = 18;
   localparam int AW = 4;

`ifdef CIC_TX_FEEDER_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic            dclk;
   logic            rst_n;
   logic            xmt;
   logic            tie;
   logic            wr;
   logic [2*DW-1:0] wdata;
   logic            flush;
   logic            err_clr;
   logic            full;
   logic [AW:0]     level;
   logic [DW-1:0]   tdix;
   logic [DW-1:0]   tdiy;
   logic            tdv;
   logic            udf;
   logic            ovf;

   int assertCount;
   int failCount;

   cic_tx_feeder #(.DW(DW), .AW(AW)) dut (
      .dclk    (dclk),
      .rst_n   (rst_n),
      .xmt     (xmt),
      .tie     (tie),
      .wr      (wr),
      .wdata   (wdata),
      .flush   (flush),
      .err_clr (err_clr),
      .full    (full),
      .level   (level),
      .tdix    (tdix),
      .tdiy    (tdiy),
      .tdv     (tdv),
      .udf     (udf),
      .ovf     (ovf)
   );

   // 100 MHz data clock.
   initial dclk = 1'b0;
   always #5 dclk = ~dclk;

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Advance one clock and land 1 ns after the edge.
   task automatic tick();
      @(posedge dclk);
      #1;
   endtask

   // Write one sample pair.
   task automatic applyStimulus(input logic [DW-1:0] x, input logic [DW-1:0] y);
      wr    = 1'b1;
      wdata = {x, y};
      tick();
      wr    = 1'b0;
   endtask

   // Issue a 2-cycle tie pulse and check the popped pair.
   task automatic popCheck(input string tag, input logic [DW-1:0] ex,
                           input logic [DW-1:0] ey);
      tie = 1'b1;
      tick();
      checkOutput({tag, ".tdv"},  64'(tdv),  64'd1);
      checkOutput({tag, ".tdix"}, 64'(tdix), 64'(ex));
      checkOutput({tag, ".tdiy"}, 64'(tdiy), 64'(ey));
      tick();
      checkOutput({tag, ".tdv_off"}, 64'(tdv), 64'd0);
      tie = 1'b0;
      tick();
   endtask

   initial begin
      logic [DW-1:0] px [3];
      logic [DW-1:0] py [3];
      logic [DW-1:0] holdX;
      logic [DW-1:0] holdY;

      assertCount = 0;
      failCount   = 0;
      rst_n   = 1'b0;
      xmt     = 1'b0;
      tie     = 1'b0;
      wr      = 1'b0;
      wdata   = '0;
      flush   = 1'b0;
      err_clr = 1'b0;

      // Reset state.
      tick();
      checkOutput("rst.level", 64'(level), 64'd0);
      checkOutput("rst.full",  64'(full),  64'd0);
      checkOutput("rst.tdix",  64'(tdix),  64'd0);
      checkOutput("rst.tdiy",  64'(tdiy),  64'd0);
      checkOutput("rst.tdv",   64'(tdv),   64'd0);
      checkOutput("rst.udf",   64'(udf),   64'd0);
      checkOutput("rst.ovf",   64'(ovf),   64'd0);
      rst_n = 1'b1;
      xmt   = 1'b1;
      tick();

      // Three pairs in, three spaced tie pulses out.
      px[0] = 18'h00001; py[0] = 18'h3FFFF;
      px[1] = 18'h1FFFF; py[1] = 18'h20000;
      px[2] = 18'h12345; py[2] = 18'h0ABCD;
      for (int i = 0; i < 3; i++) applyStimulus(px[i], py[i]);
      checkOutput("basic.level3", 64'(level), 64'd3);
      for (int i = 0; i < 3; i++) begin
         popCheck($sformatf("basic.pop%0d", i), px[i], py[i]);
         repeat (7) tick();
      end
      checkOutput("basic.level0", 64'(level), 64'd0);
      checkOutput("basic.udf",    64'(udf),   64'd0);

      // Underrun after a valid sample, then err_clr.
      applyStimulus(18'h00ABC, 18'h00DEF);
      popCheck("prior", 18'h00ABC, 18'h00DEF);
      holdX = HOLD ? 18'h00ABC : 18'h0;
      holdY = HOLD ? 18'h00DEF : 18'h0;
      tie = 1'b1;
      tick();
      checkOutput("udf.tdv",  64'(tdv),  64'd1);
      checkOutput("udf.tdix", 64'(tdix), 64'(holdX));
      checkOutput("udf.tdiy", 64'(tdiy), 64'(holdY));
      checkOutput("udf.flag", 64'(udf),  64'd1);
      tick();
      tie = 1'b0;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checkOutput("udf.clr", 64'(udf), 64'd0);

      // Write on the same cycle as a request on an empty FIFO: stored, not
      // passed through, underrun still flagged.
      tie   = 1'b1;
      wr    = 1'b1;
      wdata = {18'h01111, 18'h02222};
      tick();
      wr = 1'b0;
      checkOutput("wrudf.tdix",  64'(tdix),  64'(holdX));
      checkOutput("wrudf.udf",   64'(udf),   64'd1);
      checkOutput("wrudf.level", 64'(level), 64'd1);
      tick();
      tie = 1'b0;
      tick();
      popCheck("wrudf.pop", 18'h01111, 18'h02222);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;

      // Overrun: 17 back-to-back writes into a 16-deep FIFO.
      for (int i = 0; i < 17; i++) begin
         applyStimulus(DW'(18'h10000 + i), DW'(18'h00F00 + i));
         if (i == 15) begin
            checkOutput("ovf.full16",  64'(full),  64'd1);
            checkOutput("ovf.noovf16", 64'(ovf),   64'd0);
         end
      end
      checkOutput("ovf.flag",  64'(ovf),   64'd1);
      checkOutput("ovf.level", 64'(level), 64'd16);
      for (int i = 0; i < 16; i++)
         popCheck($sformatf("drain%0d", i), DW'(18'h10000 + i), DW'(18'h00F00 + i));
      checkOutput("drain.level", 64'(level), 64'd0);
      checkOutput("drain.udf",   64'(udf),   64'd0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checkOutput("ovf.clr", 64'(ovf), 64'd0);

      // Write and pop together while full.
      for (int i = 0; i < 16; i++) applyStimulus(DW'(18'h20000 + i), DW'(18'h00100 + i));
      tie   = 1'b1;
      wr    = 1'b1;
      wdata = {18'h2AAAA, 18'h15555};
      tick();
      wr = 1'b0;
      checkOutput("fullrw.tdix",  64'(tdix),  64'h20000);
      checkOutput("fullrw.level", 64'(level), 64'd16);
      checkOutput("fullrw.ovf",   64'(ovf),   64'd0);
      tick();
      tie = 1'b0;
      tick();
      for (int i = 1; i < 16; i++)
         popCheck($sformatf("fullrw.pop%0d", i), DW'(18'h20000 + i), DW'(18'h00100 + i));
      popCheck("fullrw.tail", 18'h2AAAA, 18'h15555);
      checkOutput("fullrw.level0", 64'(level), 64'd0);

      // Flush coincident with a request.
      for (int i = 0; i < 5; i++) applyStimulus(DW'(18'h00050 + i), DW'(18'h00060 + i));
      flush = 1'b1;
      tie   = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("flush.level", 64'(level), 64'd0);
      checkOutput("flush.tdix",  64'(tdix),  64'd0);
      checkOutput("flush.tdiy",  64'(tdiy),  64'd0);
      checkOutput("flush.udf",   64'(udf),   64'd1);
      tick();
      tie = 1'b0;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      applyStimulus(18'h0F0F0, 18'h30303);
      popCheck("flush.next", 18'h0F0F0, 18'h30303);
      checkOutput("flush.noudf", 64'(udf), 64'd0);

      // xmt low: tie ignored, outputs zero, FIFO retained.
      for (int i = 0; i < 4; i++) applyStimulus(DW'(18'h00A00 + i), DW'(18'h00B00 + i));
      xmt = 1'b0;
      tick();
      checkOutput("xmt0.tdix", 64'(tdix), 64'd0);
      tie = 1'b1;
      tick();
      checkOutput("xmt0.tdv",  64'(tdv),  64'd0);
      checkOutput("xmt0.tdiy", 64'(tdiy), 64'd0);
      tick();
      tie = 1'b0;
      tick();
      tie = 1'b1;
      tick();
      xmt = 1'b1;
      tick();
      checkOutput("xmtup.tdv",   64'(tdv),   64'd0);
      checkOutput("xmtup.level", 64'(level), 64'd4);
      tie = 1'b0;
      tick();
      popCheck("xmtup.pop", 18'h00A00, 18'h00B00);
      checkOutput("xmtup.level3", 64'(level), 64'd3);

      // Asynchronous reset mid-stream.
      for (int i = 0; i < 4; i++) applyStimulus(DW'(18'h00C00 + i), DW'(18'h00D00 + i));
      checkOutput("arst.level7", 64'(level), 64'd7);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst.level", 64'(level), 64'd0);
      checkOutput("arst.tdix",  64'(tdix),  64'd0);
      checkOutput("arst.tdiy",  64'(tdiy),  64'd0);
      checkOutput("arst.full",  64'(full),  64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
